// File: rtl/instruction_sequencer_if.sv
// Host/control-unit bundle for instruction_sequencer: program load, run control
// and the instruction handshake toward the control unit.
interface instruction_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [4:0]        prog_instr;
  logic [CNT_W-1:0]  prog_repeat;
  logic [ADDR_W:0]   prog_len;
  logic              start;
  logic              abort;
  logic              instr_ready;
  logic [4:0]        instruction;
  logic              instr_valid;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] pc;

  modport master (
    output prog_we, prog_addr, prog_instr, prog_repeat, prog_len,
    output start, abort, instr_ready,
    input  instruction, instr_valid, busy, done, pc
  );

  modport slave (
    input  prog_we, prog_addr, prog_instr, prog_repeat, prog_len,
    input  start, abort, instr_ready,
    output instruction, instr_valid, busy, done, pc
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Replays a preloaded program of 5-bit control words, holding each entry for
// repeat+1 accepted transfers, with downstream backpressure and abort.
module instruction_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  instruction_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_rep_cnt;
  logic [ADDR_W:0]   r_len;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  logic [4:0]        r_mem_instr [DEPTH];
  logic [CNT_W-1:0]  r_mem_rep   [DEPTH];

  logic [CNT_W-1:0]  w_cur_rep;
  logic              w_xfer;
  logic              w_last_entry;

  assign w_cur_rep    = r_mem_rep[r_pc];
  assign w_xfer       = r_valid & bus.instr_ready;
  assign w_last_entry = ({1'b0, r_pc} == (r_len - LEN_ONE));

  // Program store is writable only while idle so a running sequence is stable.
  always_ff @(posedge clk) begin
    if (bus.prog_we && (r_state == S_IDLE)) begin
      r_mem_instr[bus.prog_addr] <= bus.prog_instr;
      r_mem_rep[bus.prog_addr]   <= bus.prog_repeat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_rep_cnt <= '0;
      r_len     <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            r_len     <= bus.prog_len;
            r_pc      <= '0;
            r_rep_cnt <= '0;
            if (bus.prog_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Abort takes priority over any transfer seen in the same cycle.
          if (bus.abort) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_rep_cnt <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
          end else if (w_xfer) begin
            if (r_rep_cnt != w_cur_rep) begin
              r_rep_cnt <= r_rep_cnt + CNT_W'(1);
            end else if (w_last_entry) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_pc      <= r_pc + ADDR_W'(1);
              r_rep_cnt <= '0;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Decoded from registers only, so async reset clears outputs immediately.
  assign bus.instruction = r_valid ? r_mem_instr[r_pc] : 5'd0;
  assign bus.instr_valid = r_valid;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pc          = r_pc;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: directed scenarios plus random
// programs with random backpressure, checked against an expanded-program model.
module tb_instruction_sequencer;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  instruction_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int m_instr [DEPTH];
  int m_rep   [DEPTH];
  int exp_instr_q [$];
  int exp_pc_q    [$];

  int n_cmp    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name, input int act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0d, expected none (t=%0t)", name, act, $time);
  endtask

  // Monitor: pops one expected word per accepted transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.instr_valid) check("noop_when_idle", int'(bus.instruction), 0);
      check("busy_tracks_valid", int'(bus.busy), int'(bus.instr_valid));
      if (bus.instr_valid && bus.instr_ready && !bus.abort) begin
        if (exp_instr_q.size() == 0) begin
          flag_fail("unexpected_transfer", int'(bus.instruction));
        end else begin
          int ei, ep;
          ei = exp_instr_q.pop_front();
          ep = exp_pc_q.pop_front();
          check("xfer_instruction", int'(bus.instruction), ei);
          check("xfer_pc", int'(bus.pc), ep);
          $display("xfer instr=%02h pc=%0d", bus.instruction, bus.pc);
        end
      end
      if (bus.done) begin
        done_cnt++;
        check("done_words_left", exp_instr_q.size(), 0);
        check("done_valid_low", int'(bus.instr_valid), 0);
      end
    end
  end

  task automatic load(input int idx, input int instr, input int rep);
    @(posedge clk); #1;
    bus.prog_we     = 1'b1;
    bus.prog_addr   = ADDR_W'(idx);
    bus.prog_instr  = 5'(instr);
    bus.prog_repeat = CNT_W'(rep);
    m_instr[idx] = instr;
    m_rep[idx]   = rep;
    @(posedge clk); #1;
    bus.prog_we = 1'b0;
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    if (mode == 1) return (cyc == 2 || cyc == 3) ? 1'b0 : 1'b1;
    if (mode == 2) return ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
    return 1'b1;
  endfunction

  // One run: expected stream is the program expanded entry by entry.
  task automatic run(input int len, input int mode, input int inject_at,
                     input int abort_at, input int rst_at);
    int total, nready, last_xfer, d0, budget, cyc;
    bit saw_done;
    total = 0;
    for (int e = 0; e < len; e++) begin
      for (int r = 0; r <= m_rep[e]; r++) begin
        exp_instr_q.push_back(m_instr[e]);
        exp_pc_q.push_back(e);
        total++;
      end
    end
    d0 = done_cnt;
    nready = 0;
    last_xfer = 0;
    saw_done = 1'b0;
    budget = 4 * total + 50;
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.prog_len = (ADDR_W+1)'(len);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (cyc = 1; cyc <= budget; cyc++) begin
      bus.instr_ready = pick_ready(mode, cyc);
      bus.abort       = (cyc == abort_at);
      bus.start       = (cyc == inject_at);
      bus.prog_we     = (cyc == inject_at);
      bus.prog_addr   = '0;
      bus.prog_instr  = 5'h1F;
      if (bus.instr_ready && !bus.abort && nready < total) begin
        nready++;
        if (nready == total) last_xfer = cyc;
      end
      if (cyc == rst_at) begin
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", int'(bus.instr_valid), 0);
        check("async_rst_instr", int'(bus.instruction), 0);
        check("async_rst_busy", int'(bus.busy), 0);
        check("async_rst_pc", int'(bus.pc), 0);
      end
      @(negedge clk);
      if (abort_at != 0 && cyc == abort_at + 1) begin
        check("abort_valid", int'(bus.instr_valid), 0);
        check("abort_instr", int'(bus.instruction), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_pc", int'(bus.pc), 0);
      end
      if (bus.done && !rst) begin
        check("done_cycle", cyc, last_xfer + 1);
        saw_done = 1'b1;
      end
      @(posedge clk); #1;
      if (saw_done) break;
      if (abort_at != 0 && cyc >= abort_at + 3) break;
      if (rst_at != 0 && cyc >= rst_at + 2) break;
    end
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    bus.abort   = 1'b0;
    if (abort_at != 0 || rst_at != 0) begin
      check("no_done_after_cancel", done_cnt - d0, 0);
      rst = 1'b0;
      exp_instr_q.delete();
      exp_pc_q.delete();
    end else begin
      if (!saw_done) flag_fail("done_timeout", cyc);
      check("done_pulse_count", done_cnt - d0, 1);
      @(negedge clk);
      check("done_one_cycle", int'(bus.done), 0);
      check("idle_after_done", int'(bus.busy), 0);
      @(posedge clk); #1;
    end
    $display("run len=%0d mode=%0d words=%0d", len, mode, total);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_instr = '0;
    bus.prog_repeat = '0; bus.prog_len = '0; bus.start = 1'b0;
    bus.abort = 1'b0; bus.instr_ready = 1'b0;
    rst = 1'b1;
    #12;
    check("reset_valid", int'(bus.instr_valid), 0);
    check("reset_instr", int'(bus.instruction), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_pc", int'(bus.pc), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    load(0, 5'h05, 0);
    load(1, 5'h08, 2);
    load(2, 5'h13, 0);
    run(3, 0, 0, 0, 0);   // back-to-back transfers
    run(3, 1, 0, 0, 0);   // stall in cycles 2-3
    run(0, 0, 0, 0, 0);   // empty program
    run(3, 0, 0, 3, 0);   // abort mid-run
    run(3, 0, 0, 0, 0);
    run(3, 0, 2, 0, 0);   // write + start during RUN are dropped
    run(3, 0, 0, 0, 0);
    run(3, 0, 0, 0, 3);   // async reset mid-run
    run(3, 0, 0, 0, 0);

    // start with abort in IDLE: no run begins
    @(posedge clk); #1;
    bus.start = 1'b1; bus.abort = 1'b1; bus.prog_len = 5'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    check("start_abort_busy", int'(bus.busy), 0);
    check("start_abort_done", int'(bus.done), 0);
    @(posedge clk); #1;

    for (int it = 0; it < 8; it++) begin
      for (int e = 0; e < DEPTH; e++) begin
        int rep;
        rep = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 3));
        if (it == 0 && e == 0) rep = 255;
        load(e, int'($urandom_range(0, 31)), rep);
      end
      run((it == 7) ? DEPTH : int'($urandom_range(0, DEPTH)), 2, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
